// File: rtl/dct_zigzag_buf.sv
// Ping-pong 8x8 block buffer: rows in, JPEG zigzag order out, eight coefficients per beat.
// Define DCT_ZIGZAG_ERR_EN to enable the one-cycle protocol error pulse on err.
module dct_zigzag_buf #(
   parameter int DATA_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [7:0][DATA_W-1:0] in_data,
   input  logic                   in_sob,
   input  logic                   in_eob,
   input  logic                   in_sof,
   output logic                   out_valid,
   output logic [7:0][DATA_W-1:0] out_data,
   output logic                   out_sob,
   output logic                   out_eob,
   output logic                   out_sof,
   output logic                   err
);

   typedef enum logic {W_IDLE, W_FILL} w_state_t;
   typedef enum logic {R_IDLE, R_EMIT} r_state_t;

   // Raster index (8*row + col) for each zigzag position.
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic [7:0][DATA_W-1:0] mem [2][8];

   w_state_t w_state, w_next;
   logic [2:0] row, row_next, wr_row;
   logic       wb, wb_next;
   logic       we, set_full;
   logic [1:0] sof_bank;
   logic [1:0] full;

   r_state_t r_state, r_next;
   logic [2:0] cnt, cnt_next;
   logic       rb, rb_next;
   logic       emit, clr;
   logic [7:0][DATA_W-1:0] zz_beat;

   assign wr_row = in_sob ? 3'd0 : row;

   always_comb begin
      w_next   = w_state;
      row_next = row;
      wb_next  = wb;
      we       = 1'b0;
      set_full = 1'b0;
      if (in_valid) begin
         if (in_sob) begin
            we       = 1'b1;
            w_next   = W_FILL;
            row_next = 3'd1;
         end else if (w_state == W_FILL) begin
            we = 1'b1;
            if (row == 3'd7 && in_eob) begin
               set_full = 1'b1;
               wb_next  = ~wb;
               w_next   = W_IDLE;
               row_next = 3'd0;
            end else if (row == 3'd7 || in_eob) begin
               // Malformed block: abandon it, bank stays writable.
               w_next   = W_IDLE;
               row_next = 3'd0;
            end else begin
               row_next = row + 3'd1;
            end
         end
      end
   end

   always_comb begin
      r_next   = r_state;
      cnt_next = cnt;
      rb_next  = rb;
      emit     = 1'b0;
      clr      = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (full[rb]) begin
               emit     = 1'b1;
               cnt_next = 3'd1;
               r_next   = R_EMIT;
            end
         end
         R_EMIT: begin
            emit = 1'b1;
            if (cnt == 3'd7) begin
               // Return via IDLE so a full partner bank starts on the very next edge.
               clr      = 1'b1;
               rb_next  = ~rb;
               cnt_next = 3'd0;
               r_next   = R_IDLE;
            end else begin
               cnt_next = cnt + 3'd1;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      logic [5:0] idx;
      idx     = '0;
      zz_beat = '0;
      for (int k = 0; k < 8; k++) begin
         idx        = ZZ[{cnt, 3'(k)}];
         zz_beat[k] = mem[rb][idx[5:3]][idx[2:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wb][wr_row] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state   <= W_IDLE;
         row       <= 3'd0;
         wb        <= 1'b0;
         sof_bank  <= 2'b00;
         full      <= 2'b00;
         r_state   <= R_IDLE;
         cnt       <= 3'd0;
         rb        <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sob   <= 1'b0;
         out_eob   <= 1'b0;
         out_sof   <= 1'b0;
      end else begin
         w_state <= w_next;
         row     <= row_next;
         wb      <= wb_next;
         r_state <= r_next;
         cnt     <= cnt_next;
         rb      <= rb_next;
         if (in_valid && in_sob) sof_bank[wb] <= in_sof;
         if (clr)      full[rb] <= 1'b0;
         if (set_full) full[wb] <= 1'b1;
         out_valid <= emit;
         out_data  <= emit ? zz_beat : '0;
         out_sob   <= emit && (cnt == 3'd0);
         out_eob   <= emit && (cnt == 3'd7);
         out_sof   <= emit && (cnt == 3'd0) && sof_bank[rb];
      end
   end

`ifdef DCT_ZIGZAG_ERR_EN
   logic err_det;

   // Flags dropped idle beats, early/missing eob, and sob cutting into a block.
   always_comb begin
      err_det = in_valid &
                (in_sob ? (w_state == W_FILL)
                        : ((w_state == W_IDLE) | (in_eob != (row == 3'd7))));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= err_det;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dct_zigzag_buf.sv
// Directed bench for dct_zigzag_buf: zigzag data, markers, latency, gaps, errors, reset abort.
module tb_dct_zigzag_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             in_valid;
   logic [7:0][15:0] in_data;
   logic             in_sob;
   logic             in_eob;
   logic             in_sof;
   logic             out_valid;
   logic [7:0][15:0] out_data;
   logic             out_sob;
   logic             out_eob;
   logic             out_sof;
   logic             err;

   dct_zigzag_buf #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
      .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob),
      .out_eob(out_eob), .out_sof(out_sof), .err(err)
   );

   typedef struct {
      logic [127:0] d;
      logic         sob;
      logic         eob;
      logic         sof;
      int           cyc;
   } beat_t;

   beat_t       q[$];
   int          cyc = 0;
   int          err_cnt = 0;
   int          checks = 0;
   int          errors = 0;
   int          zr[64];
   int          zc[64];
   logic [15:0] blks [4][8][8];
   int          first_cyc;
   int          last_eob;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (out_valid) begin
         beat_t b;
         b.d   = out_data;
         b.sob = out_sob;
         b.eob = out_eob;
         b.sof = out_sof;
         b.cyc = cyc;
         q.push_back(b);
      end
      if (err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_row(input int n, input int r, input logic sob, input logic eob, input logic sof);
      logic [7:0][15:0] rw;
      for (int c = 0; c < 8; c++) rw[c] = blks[n][r][c];
      in_valid = 1'b1;
      in_data  = rw;
      in_sob   = sob;
      in_eob   = eob;
      in_sof   = sof;
      step();
      in_valid = 1'b0;
      in_sob   = 1'b0;
      in_eob   = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
   endtask

   task automatic send_block(input int n, input logic sof, input int gap);
      for (int r = 0; r < 8; r++) begin
         send_row(n, r, r == 0, r == 7, sof && (r == 0));
         if (r == 0) first_cyc = cyc;
         if (r == 7) last_eob = cyc;
         else idle(gap);
      end
   endtask

   function automatic logic [127:0] exp_beat(input int n, input int b);
      logic [7:0][15:0] e;
      for (int k = 0; k < 8; k++) e[k] = blks[n][zr[8*b+k]][zc[8*b+k]];
      return e;
   endfunction

   task automatic check_block(input string tag, input int qi, input int n);
      if (q.size() < qi + 8) begin
         chk({tag, "_count"}, q.size(), qi + 8);
         return;
      end
      for (int b = 0; b < 8; b++)
         chk($sformatf("%s_beat%0d", tag, b), q[qi+b].d, exp_beat(n, b));
      chk({tag, "_marks"}, {q[qi].sob, q[qi+1].sob, q[qi+6].eob, q[qi+7].eob, q[qi+7].cyc - q[qi].cyc},
          {1'b1, 1'b0, 1'b0, 1'b1, 32'd7});
   endtask

   initial begin
      logic [7:0][15:0] exp0;
      int z, sofs, e0;

      // Zigzag walk along anti-diagonals, alternating direction.
      z = 0;
      for (int s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
               zr[z] = r; zc[z] = s - r; z++;
            end
         end else begin
            for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
               zr[z] = r; zc[z] = s - r; z++;
            end
         end
      end
      for (int n = 0; n < 4; n++)
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
               blks[n][r][c] = 16'((n << 8) | (8 * r + c));

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
      idle(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_marks", {out_sob, out_eob, out_sof, err}, 0);
      rst = 1'b0;
      idle(2);
      q.delete();

      // Single block, row r lane c = 8r+c
      send_block(0, 1'b1, 0);
      idle(12);
      chk("t1_count", q.size(), 8);
      if (q.size() >= 8) begin
         exp0 = {16'd10, 16'd3, 16'd2, 16'd9, 16'd16, 16'd8, 16'd1, 16'd0};
         chk("t1_beat0_const", q[0].d, exp0);
         chk("t1_last_coef", q[7].d[127:112], 63);
         chk("t1_latency", q[0].cyc, first_cyc + 8);
         chk("t1_sof", q[0].sof, 1);
      end
      check_block("t1", 0, 0);
      q.delete();

      // Four back-to-back blocks
      send_block(0, 1'b1, 0);
      send_block(1, 1'b0, 0);
      send_block(2, 1'b0, 0);
      send_block(3, 1'b0, 0);
      idle(12);
      chk("t2_count", q.size(), 32);
      for (int n = 0; n < 4; n++) check_block($sformatf("t2_blk%0d", n), 8 * n, n);
      if (q.size() >= 32) begin
         sofs = 0;
         foreach (q[i]) sofs += int'(q[i].sof);
         chk("t2_sof_first", q[0].sof, 1);
         chk("t2_sof_total", sofs, 1);
         chk("t2_span", q[31].cyc - q[0].cyc, 31);
      end
      q.delete();

      // Gapped input rows
      send_block(1, 1'b0, 5);
      idle(12);
      chk("t3_count", q.size(), 8);
      if (q.size() >= 1) chk("t3_latency", q[0].cyc, last_eob + 1);
      check_block("t3", 0, 1);
      q.delete();

      // Early eob at row 4, then a good block
      e0 = err_cnt;
      for (int r = 0; r < 5; r++) send_row(1, r, r == 0, r == 4, 1'b0);
      send_block(2, 1'b0, 0);
      idle(12);
      chk("t4_count", q.size(), 8);
      check_block("t4", 0, 2);
`ifdef DCT_ZIGZAG_ERR_EN
      chk("t4_err_pulses", err_cnt - e0, 1);
`else
      chk("t4_err_pulses", err_cnt - e0, 0);
`endif
      q.delete();

      // Reset during output beat 3
      send_block(3, 1'b0, 0);
      idle(4);
      chk("t5_pre_valid", {out_valid, out_sob}, {1'b1, 1'b0});
      chk("t5_pre_beat3", out_data, exp_beat(3, 3));
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_data", out_data, 0);
      chk("t5_rst_marks", {out_sob, out_eob, out_sof, err}, 0);
      idle(2);
      rst = 1'b0;
      q.delete();
      idle(3);
      chk("t5_quiet", q.size(), 0);
      send_block(0, 1'b0, 0);
      idle(12);
      chk("t5_count", q.size(), 8);
      check_block("t5", 0, 0);
      q.delete();

      // Signed extremes
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            blks[3][r][c] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      blks[3][0][0] = 16'h8000;
      blks[3][7][7] = 16'h7FFF;
      send_block(3, 1'b0, 0);
      idle(12);
      chk("t6_count", q.size(), 8);
      check_block("t6", 0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
